// File: rtl/xyolo_vwrite_pingpong.sv
// xyolo_vwrite_pingpong
//   Ping-pong result buffer between the xyolo compute units and the databus.
//   The compute side fills bank wbank (one word per channel per entry) while
//   the other bank is drained entry by entry.
//   Each entry is cut into BEATS databus beats. Inactive channels are masked
//   through wstrb.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   wr_en/addr/data   per-channel compute write into bank wbank
//   swap, swap_ready  hand the filled bank over for draining (accepted when both high)
//   cfg_*             drain base address, length, stride, active channels (latched on accept)
//   wbank             bank currently owned by the compute side
//   done              one-cycle pulse after a drain completes
//   databus_*         write beat: valid/ready handshake plus addr, wdata, wstrb
//   dbg_state         drain FSM state (IDLE=0, FETCH=1, SEND=2, DONE=3)
//
// Handshake: a beat transfers on a rising edge where databus_valid and
// databus_ready are both high. Once valid is raised, addr/wdata/wstrb are held
// until that transfer happens. Ready may toggle freely.
module xyolo_vwrite_pingpong #(
   parameter int DATAPATH_W = 32,
   parameter int N_CH       = 16,
   parameter int DEPTH_W    = 6,
   parameter int DATABUS_W  = 256,
   parameter int IO_ADDR_W  = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_CH-1:0]               wr_en,
   input  logic [DEPTH_W-1:0]            wr_addr,
   input  logic [N_CH*DATAPATH_W-1:0]    wr_data,
   input  logic                          swap,
   output logic                          swap_ready,
   input  logic [IO_ADDR_W-1:0]          cfg_ext_addr,
   input  logic [DEPTH_W:0]              cfg_len,
   input  logic [IO_ADDR_W-1:0]          cfg_stride,
   input  logic [$clog2(N_CH+1)-1:0]     cfg_n_ch,
   output logic                          wbank,
   output logic                          done,
   output logic                          databus_valid,
   input  logic                          databus_ready,
   output logic [IO_ADDR_W-1:0]          databus_addr,
   output logic [DATABUS_W-1:0]          databus_wdata,
   output logic [DATABUS_W/8-1:0]        databus_wstrb,
   output logic [1:0]                    dbg_state
);

   localparam int ENTRY_W   = N_CH * DATAPATH_W;
   localparam int BEATS     = (ENTRY_W + DATABUS_W - 1) / DATABUS_W;
   localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BUS_BYTES = DATABUS_W / 8;
   localparam int NCH_W     = $clog2(N_CH + 1);
   localparam int WORDS     = 2 ** (DEPTH_W + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_SEND  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                 state;
   logic                       fetch_hold;
   logic                       dbank;
   logic [DEPTH_W:0]           len_q;
   logic [DEPTH_W:0]           entry;
   logic [BEAT_W-1:0]          beat;
   logic [IO_ADDR_W-1:0]       entry_addr;
   logic [IO_ADDR_W-1:0]       stride_q;
   logic [NCH_W-1:0]           n_ch_q;

   // Both banks share one array per channel; the bank is the top address bit.
   logic [DATAPATH_W-1:0]      mem [N_CH][WORDS];
   logic [ENTRY_W-1:0]         rd_q;
   logic [BEATS*DATABUS_W-1:0] rd_ext;
   logic [BEATS*DATABUS_W-1:0] hold_q;

   assign swap_ready = (state == S_IDLE);
   assign dbg_state  = state;

   // Byte j of beat b is enabled when the channel owning that byte is active.
   function automatic logic [BUS_BYTES-1:0] beat_strb(input logic [BEAT_W-1:0] b,
                                                      input logic [NCH_W-1:0]  n);
      logic [BUS_BYTES-1:0] s;
      for (int j = 0; j < BUS_BYTES; j++)
         s[j] = ((int'(b) * DATABUS_W + 8 * j) / DATAPATH_W) < int'(n);
      return s;
   endfunction

   // Entry zero-extended to a whole number of beats.
   always_comb begin
      rd_ext              = '0;
      rd_ext[ENTRY_W-1:0] = rd_q;
   end

   // Storage: the compute write commits on the edge where wr_en is sampled, so
   // a write issued together with an accepted swap is already in the array
   // when the first drain read happens one edge later. The read port follows
   // the current entry every cycle.
   always_ff @(posedge clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (wr_en[c])
            mem[c][{wbank, wr_addr}] <= wr_data[c*DATAPATH_W +: DATAPATH_W];
         rd_q[c*DATAPATH_W +: DATAPATH_W] <= mem[c][{dbank, entry[DEPTH_W-1:0]}];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_IDLE;
         fetch_hold    <= 1'b0;
         wbank         <= 1'b0;
         dbank         <= 1'b0;
         done          <= 1'b0;
         databus_valid <= 1'b0;
         databus_addr  <= '0;
         databus_wdata <= '0;
         databus_wstrb <= '0;
         beat          <= '0;
         entry         <= '0;
         len_q         <= '0;
         entry_addr    <= '0;
         stride_q      <= '0;
         n_ch_q        <= '0;
         hold_q        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (swap) begin
                  wbank      <= ~wbank;
                  dbank      <= wbank;
                  len_q      <= cfg_len;
                  entry_addr <= cfg_ext_addr;
                  stride_q   <= cfg_stride;
                  n_ch_q     <= (cfg_n_ch == '0 || cfg_n_ch > NCH_W'(N_CH)) ?
                                NCH_W'(N_CH) : cfg_n_ch;
                  entry      <= '0;
                  beat       <= '0;
                  fetch_hold <= 1'b0;
                  state      <= (cfg_len == '0) ? S_DONE : S_FETCH;
               end
            end
            // Two cycles: the first lets the RAM read land in rd_q, the second
            // moves it into the holding register and presents beat 0.
            S_FETCH: begin
               fetch_hold <= ~fetch_hold;
               if (fetch_hold) begin
                  hold_q        <= rd_ext;
                  databus_valid <= 1'b1;
                  databus_addr  <= entry_addr;
                  databus_wdata <= rd_ext[DATABUS_W-1:0];
                  databus_wstrb <= beat_strb('0, n_ch_q);
                  state         <= S_SEND;
               end
            end
            S_SEND: begin
               if (databus_ready) begin
                  if (int'(beat) < BEATS - 1) begin
                     beat          <= beat + 1'b1;
                     databus_addr  <= databus_addr + IO_ADDR_W'(BUS_BYTES);
                     databus_wdata <= hold_q[(int'(beat) + 1) * DATABUS_W +: DATABUS_W];
                     databus_wstrb <= beat_strb(beat + 1'b1, n_ch_q);
                  end else begin
                     beat          <= '0;
                     databus_valid <= 1'b0;
                     if (entry + 1'b1 < len_q) begin
                        entry      <= entry + 1'b1;
                        entry_addr <= entry_addr + stride_q;
                        state      <= S_FETCH;
                     end else begin
                        state <= S_DONE;
                     end
                  end
               end
            end
            default: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
